// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the 18-bit-instruction pipeline.
//  - Load-use hazard between Decode and Execute: one-cycle stall with a bubble
//    loaded into Decode/Execute.
//  - Multi-cycle Execute ops (multiply): holds the front end and Decode/Execute
//    and bubbles Execute/Memory for MUL_LATENCY-1 cycles after the start pulse.
//  - Branch mispredict: flushes Fetch/Decode for FLUSH_CYCLES cycles and
//    bubbles Decode/Execute on the mispredict cycle. Highest priority.
//  - Saturating performance counters for stall cycles and mispredicts.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   Daddress1/2    Decode source registers, Duse1/2 their read enables
//   Ememread       Execute instruction is a load, Edest its destination
//   Emulstart      multi-cycle op entered Execute (pulse)
//   Emispredict    branch in Execute mispredicted (pulse)
//   clear_counters synchronous clear of both performance counters
//   Fstall/Dstall/Estall     hold PC / Fetch-Decode / Decode-Execute
//   FDflush/DEflush/EMbubble clear F/D, bubble D/E, bubble E/M
//   busy_state     0 RUN, 1 MULBUSY, 2 FLUSH
//   stall_count    cycles with Dstall=1 (saturating)
//   flush_count    accepted mispredict pulses (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int MUL_LATENCY  = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Daddress1,
  input  logic [3:0]  Daddress2,
  input  logic        Duse1,
  input  logic        Duse2,
  input  logic        Ememread,
  input  logic [3:0]  Edest,
  input  logic        Emulstart,
  input  logic        Emispredict,
  input  logic        clear_counters,
  output logic        Fstall,
  output logic        Dstall,
  output logic        Estall,
  output logic        FDflush,
  output logic        DEflush,
  output logic        EMbubble,
  output logic [1:0]  busy_state,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  localparam int CW = 4;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MULBUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;
  logic [15:0]   flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic fstall_c, dstall_c, estall_c, fdflush_c, deflush_c, embubble_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  // Edest==0 is the hard-wired zero register, so it never creates a hazard.
  assign load_use = Ememread && (Edest != 4'd0) &&
                    ((Duse1 && (Daddress1 == Edest)) ||
                     (Duse2 && (Daddress2 == Edest)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fstall_c   = 1'b0;
    dstall_c   = 1'b0;
    estall_c   = 1'b0;
    fdflush_c  = 1'b0;
    deflush_c  = 1'b0;
    embubble_c = 1'b0;

    if (Emispredict) begin
      // Fetch is being redirected, so nothing is held; a multiply in flight
      // (protocol violation) is abandoned and a flush in progress restarts.
      fdflush_c = 1'b1;
      deflush_c = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = CW'(FLUSH_CYCLES - 1);
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (Emulstart) begin
            state_d = MULBUSY;
            cnt_d   = CW'(MUL_LATENCY - 1);
          end else if (load_use) begin
            // The load leaves Execute next cycle, so one stall cycle suffices.
            fstall_c  = 1'b1;
            dstall_c  = 1'b1;
            deflush_c = 1'b1;
          end
        end
        MULBUSY: begin
          fstall_c   = 1'b1;
          dstall_c   = 1'b1;
          estall_c   = 1'b1;
          embubble_c = 1'b1;
          cnt_d      = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        FLUSH: begin
          fdflush_c = 1'b1;
          cnt_d     = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = RUN;
        end
        default: begin
          // Unreachable encoding: outputs stay quiet and the FSM recovers.
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Controls are forced low for as long as reset is held.
  assign Fstall   = reset & fstall_c;
  assign Dstall   = reset & dstall_c;
  assign Estall   = reset & estall_c;
  assign FDflush  = reset & fdflush_c;
  assign DEflush  = reset & deflush_c;
  assign EMbubble = reset & embubble_c;

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, Dstall);
    flush_cnt_d = sat_inc(flush_cnt_q, Emispredict);
    if (clear_counters) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign busy_state  = state_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  localparam int MUL_LAT = 4;
  localparam int FL_CYC  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Daddress1, Daddress2, Edest;
  logic        Duse1, Duse2, Ememread, Emulstart, Emispredict, clear_counters;
  logic        Fstall, Dstall, Estall, FDflush, DEflush, EMbubble;
  logic [1:0]  busy_state;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining multiply-stall cycles, remaining flush-only
  // cycles, and the two performance counters as plain integers.
  int m_mul   = 0;
  int m_flush = 0;
  int m_stall = 0;
  int m_fcnt  = 0;
  int fd_seen = 0;
  int base;

  pipeline_hazard_controller #(
    .MUL_LATENCY (MUL_LAT),
    .FLUSH_CYCLES(FL_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Daddress1     (Daddress1),
    .Daddress2     (Daddress2),
    .Duse1         (Duse1),
    .Duse2         (Duse2),
    .Ememread      (Ememread),
    .Edest         (Edest),
    .Emulstart     (Emulstart),
    .Emispredict   (Emispredict),
    .clear_counters(clear_counters),
    .Fstall        (Fstall),
    .Dstall        (Dstall),
    .Estall        (Estall),
    .FDflush       (FDflush),
    .DEflush       (DEflush),
    .EMbubble      (EMbubble),
    .busy_state    (busy_state),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Daddress1 = 4'd0; Daddress2 = 4'd0; Edest = 4'd0;
    Duse1 = 1'b0; Duse2 = 1'b0; Ememread = 1'b0;
    Emulstart = 1'b0; Emispredict = 1'b0; clear_counters = 1'b0;
  endtask

  task automatic set_load_use(input logic [3:0] dst);
    Ememread = 1'b1; Edest = dst; Daddress2 = dst; Duse2 = 1'b1;
  endtask

  task automatic model_reset();
    m_mul = 0; m_flush = 0; m_stall = 0; m_fcnt = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_Fstall"},   32'(Fstall),   32'd0);
    chk({tag, "_Dstall"},   32'(Dstall),   32'd0);
    chk({tag, "_Estall"},   32'(Estall),   32'd0);
    chk({tag, "_FDflush"},  32'(FDflush),  32'd0);
    chk({tag, "_DEflush"},  32'(DEflush),  32'd0);
    chk({tag, "_EMbubble"}, 32'(EMbubble), 32'd0);
    chk({tag, "_busy"},     32'(busy_state), 32'd0);
    chk({tag, "_stallcnt"}, 32'(stall_count), 32'd0);
  endtask

  // One clock cycle with the currently driven inputs. Inputs are applied
  // just after a rising edge; outputs are sampled on the falling edge.
  task automatic tick(input bit do_check);
    bit ld, fs, ds, es, fd, de, eb;
    int busy;
    ld = Ememread && (Edest != 4'd0) &&
         ((Duse1 && (Daddress1 == Edest)) || (Duse2 && (Daddress2 == Edest)));
    fs = 0; ds = 0; es = 0; fd = 0; de = 0; eb = 0;
    busy = (m_mul > 0) ? 1 : ((m_flush > 0) ? 2 : 0);
    if (Emispredict) begin
      fd = 1; de = 1;
    end else if (m_mul > 0) begin
      fs = 1; ds = 1; es = 1; eb = 1;
    end else if (m_flush > 0) begin
      fd = 1;
    end else if (!Emulstart && ld) begin
      fs = 1; ds = 1; de = 1;
    end
    if (do_check) begin
      @(negedge clk);
      chk("Fstall",   32'(Fstall),   32'(fs));
      chk("Dstall",   32'(Dstall),   32'(ds));
      chk("Estall",   32'(Estall),   32'(es));
      chk("FDflush",  32'(FDflush),  32'(fd));
      chk("DEflush",  32'(DEflush),  32'(de));
      chk("EMbubble", 32'(EMbubble), 32'(eb));
      chk("busy_state",  32'(busy_state),  32'(busy));
      chk("stall_count", 32'(stall_count), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_fcnt));
      fd_seen += int'(FDflush);
    end
    @(posedge clk);
    #1;
    if (Emispredict) begin
      m_mul = 0;
      m_flush = FL_CYC - 1;
    end else if (m_mul > 0) begin
      m_mul--;
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (Emulstart) begin
      m_mul = MUL_LAT - 1;
    end
    if (clear_counters) begin
      m_stall = 0;
      m_fcnt  = 0;
    end else begin
      if (ds && m_stall < 65535) m_stall++;
      if (Emispredict && m_fcnt < 65535) m_fcnt++;
    end
  endtask

  initial begin
    // Reset with a live load-use pattern on the inputs.
    idle();
    reset = 1'b0;
    set_load_use(4'd7);
    Duse1 = 1'b1; Daddress1 = 4'd7;
    #2;
    chk_quiet("in_reset");
    repeat (2) @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    model_reset();
    tick(1);

    // Load-use on source 2: exactly one stall cycle.
    base = m_stall;
    set_load_use(4'd5);
    tick(1);
    idle();
    tick(1);
    chk("loaduse_stallcnt", 32'(stall_count), 32'(base + 1));
    // Destination r0 never stalls.
    set_load_use(4'd0);
    tick(1);
    chk("r0_no_stall", 32'(stall_count), 32'(base + 1));
    idle();

    // Multiply: pulse at T, stalls T+1..T+3 with load-use held true.
    base = m_stall;
    Emulstart = 1'b1;
    tick(1);
    Emulstart = 1'b0;
    set_load_use(4'd9);
    repeat (MUL_LAT - 1) tick(1);
    idle();
    tick(1);
    chk("mul_stallcnt", 32'(stall_count), 32'(base + MUL_LAT - 1));
    chk("mul_back_run", 32'(busy_state), 32'd0);

    // Mispredict together with a load-use match.
    base = m_fcnt;
    set_load_use(4'd3);
    Emispredict = 1'b1;
    #1;
    chk("mp_Dstall",  32'(Dstall),  32'd0);
    chk("mp_FDflush", 32'(FDflush), 32'd1);
    chk("mp_DEflush", 32'(DEflush), 32'd1);
    tick(1);
    idle();
    repeat (3) tick(1);
    chk("mp_flushcnt", 32'(flush_count), 32'(base + 1));

    // Mispredict, then a second pulse one cycle later: 4 flush cycles.
    fd_seen = 0;
    Emispredict = 1'b1;
    tick(1);
    tick(1);
    Emispredict = 1'b0;
    repeat (4) tick(1);
    chk("flush_extend_cycles", 32'(fd_seen), 32'd4);

    // Reset asserted mid-multiply while the counter is at 2.
    Emulstart = 1'b1;
    tick(1);
    Emulstart = 1'b0;
    tick(1);
    chk("pre_reset_busy", 32'(busy_state), 32'd1);
    set_load_use(4'd6);
    #2;
    reset = 1'b0;
    #1;
    chk_quiet("mid_mul_reset");
    model_reset();
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    Emulstart = 1'b1;
    tick(1);
    Emulstart = 1'b0;
    repeat (MUL_LAT) tick(1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      Daddress1      = 4'($urandom_range(0, 3));
      Daddress2      = 4'($urandom_range(0, 3));
      Edest          = 4'($urandom_range(0, 3));
      Duse1          = 1'($urandom_range(0, 1));
      Duse2          = 1'($urandom_range(0, 1));
      Ememread       = 1'($urandom_range(0, 1));
      Emulstart      = ($urandom_range(0, 7) == 0);
      Emispredict    = ($urandom_range(0, 9) == 0);
      clear_counters = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    idle();
    repeat (FL_CYC + MUL_LAT) tick(1);

    // Saturation of stall_count.
    clear_counters = 1'b1;
    tick(1);
    clear_counters = 1'b0;
    chk("cleared", 32'(stall_count), 32'd0);
    set_load_use(4'd12);
    repeat (65534) tick(0);
    chk("preload_fffe", 32'(stall_count), 32'hFFFE);
    repeat (3) tick(1);
    chk("saturated", 32'(stall_count), 32'hFFFF);
    clear_counters = 1'b1;
    tick(1);
    clear_counters = 1'b0;
    chk("clear_beats_inc", 32'(stall_count), 32'd0);
    idle();
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
